// File: rtl/sha1_wb_sequencer.sv
// Wishbone master that runs one 16-word block through the SHA-1 peripheral and returns the digest.
// Optional: define SHA1_SEQ_IDCHECK_EN to read and verify the peripheral ID before touching it.
module sha1_wb_sequencer #(
  parameter logic [31:0] BASE_ADDRESS = 32'h3000_0024,
  parameter int unsigned POLL_GAP     = 8,
  parameter int unsigned ACK_TIMEOUT  = 32,
  parameter int unsigned MAX_POLLS    = 1024
) (
  input  logic         wb_clk_i,
  input  logic         reset,
  input  logic         start,
  input  logic         msg_valid,
  input  logic [31:0]  msg_data,
  output logic         msg_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic [2:0]   err_code,
  output logic [159:0] digest_o,
  output logic         wbm_cyc_o,
  output logic         wbm_stb_o,
  output logic         wbm_we_o,
  output logic [3:0]   wbm_sel_o,
  output logic [31:0]  wbm_adr_o,
  output logic [31:0]  wbm_dat_o,
  input  logic [31:0]  wbm_dat_i,
  input  logic         wbm_ack_i
);

  localparam logic [31:0] ADR_OPS = BASE_ADDRESS + 32'h8;
  localparam logic [31:0] ADR_MSG = BASE_ADDRESS + 32'hC;
  localparam logic [31:0] ADR_DIG = BASE_ADDRESS + 32'h10;
  localparam int          PCW     = $clog2(MAX_POLLS + 1);

  typedef enum logic [3:0] {
    S_IDLE,
`ifdef SHA1_SEQ_IDCHECK_EN
    S_ID_RD,
`endif
    S_RST_WR, S_MSG_WAIT, S_MSG_WR, S_POLL_WAIT, S_POLL_RD,
    S_DIG_RD, S_OFF_WR, S_DONE, S_ERROR
  } state_t;

`ifdef SHA1_SEQ_IDCHECK_EN
  localparam logic [31:0] ADR_ID      = BASE_ADDRESS + 32'h4;
  localparam logic [31:0] PERIPH_ID   = 32'h5348_4131;
  localparam state_t      START_STATE = S_ID_RD;
`else
  localparam state_t      START_STATE = S_RST_WR;
`endif

  state_t           state;
  logic [31:0]      msg_word;
  logic [3:0]       word_cnt;
  logic [PCW-1:0]   poll_cnt;
  logic [7:0]       gap_cnt;
  logic [7:0]       to_cnt;
  logic [2:0]       dig_idx;
  logic             bus_gap;

  logic             req_valid, req_we;
  logic [31:0]      req_adr, req_dat;
  logic             issue, ack_hit, timeout;

  assign wbm_sel_o = 4'hF;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_adr   = ADR_OPS;
    req_dat   = '0;
    case (state)
`ifdef SHA1_SEQ_IDCHECK_EN
      S_ID_RD:   req_adr = ADR_ID;
`endif
      S_RST_WR:  begin req_we = 1'b1; req_dat = 32'h2; end
      S_MSG_WR:  begin req_we = 1'b1; req_adr = ADR_MSG; req_dat = msg_word; end
      S_POLL_RD: req_adr = ADR_OPS;
      S_DIG_RD:  req_adr = ADR_DIG;
      S_OFF_WR:  req_we = 1'b1;
      default:   req_valid = 1'b0;
    endcase
  end

  // Ack only counts while our strobe is up; a trailing ack after the drop is ignored.
  assign ack_hit = wbm_cyc_o & wbm_stb_o & wbm_ack_i;
  assign issue   = req_valid & ~wbm_cyc_o & ~bus_gap;
  assign timeout = wbm_stb_o & ~wbm_ack_i & (to_cnt == 8'(ACK_TIMEOUT - 1));

  // NOTE: sequential state uses non-blocking assignments only, so every branch sees pre-edge values.
  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      state     <= S_IDLE;
      msg_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
      err_code  <= '0;
      digest_o  <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      msg_word  <= '0;
      word_cnt  <= '0;
      poll_cnt  <= '0;
      gap_cnt   <= '0;
      to_cnt    <= '0;
      dig_idx   <= '0;
      bus_gap   <= 1'b0;
    end else begin
      if (bus_gap) bus_gap <= 1'b0;

      if (issue) begin
        wbm_cyc_o <= 1'b1;
        wbm_stb_o <= 1'b1;
        wbm_we_o  <= req_we;
        wbm_adr_o <= req_adr;
        wbm_dat_o <= req_dat;
        to_cnt    <= '0;
      end else if (ack_hit) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_adr_o <= '0;
        wbm_dat_o <= '0;
        bus_gap   <= 1'b1;
      end else if (timeout) begin
        wbm_cyc_o <= 1'b0;
        wbm_stb_o <= 1'b0;
        wbm_we_o  <= 1'b0;
        wbm_adr_o <= '0;
        wbm_dat_o <= '0;
        state     <= S_ERROR;
        busy      <= 1'b0;
        error     <= 1'b1;
        err_code  <= 3'd1;
      end else if (wbm_stb_o && to_cnt != 8'hFF) begin
        to_cnt <= to_cnt + 8'd1;
      end

      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            busy     <= 1'b1;
            done     <= 1'b0;
            error    <= 1'b0;
            err_code <= '0;
            digest_o <= '0;
            word_cnt <= '0;
            poll_cnt <= '0;
            dig_idx  <= '0;
            state    <= START_STATE;
          end
        end
`ifdef SHA1_SEQ_IDCHECK_EN
        S_ID_RD: begin
          if (ack_hit) begin
            if (wbm_dat_i != PERIPH_ID) begin
              state    <= S_ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 3'd4;
            end else begin
              state <= S_RST_WR;
            end
          end
        end
`endif
        S_RST_WR: begin
          if (ack_hit) begin
            state     <= S_MSG_WAIT;
            msg_ready <= 1'b1;
          end
        end
        S_MSG_WAIT: begin
          if (msg_valid && msg_ready) begin
            msg_word  <= msg_data;
            msg_ready <= 1'b0;
            state     <= S_MSG_WR;
          end
        end
        S_MSG_WR: begin
          if (ack_hit) begin
            if (word_cnt == 4'd15) begin
              state   <= S_POLL_WAIT;
              gap_cnt <= '0;
            end else begin
              word_cnt  <= word_cnt + 4'd1;
              msg_ready <= 1'b1;
              state     <= S_MSG_WAIT;
            end
          end
        end
        S_POLL_WAIT: begin
          if (gap_cnt == 8'(POLL_GAP - 1)) state <= S_POLL_RD;
          else gap_cnt <= gap_cnt + 8'd1;
        end
        S_POLL_RD: begin
          if (ack_hit) begin
            if (wbm_dat_i[2]) begin
              state    <= S_ERROR;
              busy     <= 1'b0;
              error    <= 1'b1;
              err_code <= 3'd2;
            end else if (wbm_dat_i[3]) begin
              state   <= S_DIG_RD;
              dig_idx <= '0;
            end else begin
              poll_cnt <= poll_cnt + 1'b1;
              if (poll_cnt == PCW'(MAX_POLLS - 1)) begin
                state    <= S_ERROR;
                busy     <= 1'b0;
                error    <= 1'b1;
                err_code <= 3'd3;
              end else begin
                state   <= S_POLL_WAIT;
                gap_cnt <= '0;
              end
            end
          end
        end
        S_DIG_RD: begin
          if (ack_hit) begin
            digest_o[32*dig_idx +: 32] <= wbm_dat_i;
            if (dig_idx == 3'd4) state <= S_OFF_WR;
            else dig_idx <= dig_idx + 3'd1;
          end
        end
        S_OFF_WR: begin
          if (ack_hit) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_wb_sequencer.sv
// Self-checking bench for sha1_wb_sequencer: register-map target model plus a bus-op scoreboard.
// Honours SHA1_SEQ_IDCHECK_EN the same way the design does.
module tb_sha1_wb_sequencer;

  localparam logic [31:0] BASE    = 32'h3000_0024;
  localparam logic [31:0] ADR_ID  = BASE + 32'h4;
  localparam logic [31:0] ADR_OPS = BASE + 32'h8;
  localparam logic [31:0] ADR_MSG = BASE + 32'hC;
  localparam logic [31:0] ADR_DIG = BASE + 32'h10;
  localparam int          GAP     = 8;
  localparam int          TMO     = 32;
  localparam int          MAXP    = 1024;
  localparam logic [31:0] ID_OK   = 32'h5348_4131;
`ifdef SHA1_SEQ_IDCHECK_EN
  localparam int          PRE_OPS = 2;
`else
  localparam int          PRE_OPS = 1;
`endif

  typedef struct packed {
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat;
  } op_t;

  logic         wb_clk_i = 1'b0;
  logic         reset, start, msg_valid, msg_ready;
  logic [31:0]  msg_data;
  logic         busy, done, error;
  logic [2:0]   err_code;
  logic [159:0] digest_o;
  logic         wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_ack_i;
  logic [3:0]   wbm_sel_o;
  logic [31:0]  wbm_adr_o, wbm_dat_o, wbm_dat_i;

  always #5 wb_clk_i = ~wb_clk_i;

  sha1_wb_sequencer #(
    .BASE_ADDRESS(BASE), .POLL_GAP(GAP), .ACK_TIMEOUT(TMO), .MAX_POLLS(MAXP)
  ) dut (
    .wb_clk_i(wb_clk_i), .reset(reset), .start(start),
    .msg_valid(msg_valid), .msg_data(msg_data), .msg_ready(msg_ready),
    .busy(busy), .done(done), .error(error), .err_code(err_code), .digest_o(digest_o),
    .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i)
  );

  // ---------------- target model ----------------
  logic        clr_req = 1'b1;
  logic        mute_first_wr = 1'b0, panic_mode = 1'b0, never_done = 1'b0;
  logic [31:0] id_value = ID_OK;
  logic [31:0] dig_words [5] = '{32'hA999_3E36, 32'h4706_816A, 32'hBA3E_2571,
                                 32'h7850_C26C, 32'h9CD0_D89D};
  logic        ack;
  logic [31:0] rdata;
  op_t         obs_mem [2048];
  int          obs_n, n_wr, n_ops_rd, n_dig, stb_run, max_run;

  assign wbm_ack_i = ack;
  assign wbm_dat_i = rdata;

  function automatic logic [31:0] read_val(input logic [31:0] adr);
    int k;
    k = n_ops_rd + 1;
    if (adr == ADR_ID) return id_value;
    if (adr == ADR_DIG) return (n_dig < 5) ? dig_words[n_dig] : 32'h0;
    if (adr == ADR_OPS) begin
      if (panic_mode && k == 3) return 32'hC;
      if (!never_done && k >= 3) return 32'h8;
    end
    return 32'h0;
  endfunction

  always @(posedge wb_clk_i) begin
    if (clr_req) begin
      ack <= 1'b0; rdata <= '0; obs_n <= 0; n_wr <= 0; n_ops_rd <= 0;
      n_dig <= 0; stb_run <= 0; max_run <= 0;
    end else begin
      if (wbm_stb_o && !ack) begin
        stb_run <= stb_run + 1;
        if (stb_run + 1 > max_run) max_run <= stb_run + 1;
      end else begin
        stb_run <= 0;
      end
      if (wbm_cyc_o && wbm_stb_o && ack) begin
        ack <= 1'b0;
        if (obs_n < 2048) obs_mem[obs_n] <= '{wbm_we_o, wbm_adr_o, wbm_we_o ? wbm_dat_o : 32'h0};
        obs_n <= obs_n + 1;
        if (wbm_we_o) n_wr <= n_wr + 1;
        else if (wbm_adr_o == ADR_OPS) n_ops_rd <= n_ops_rd + 1;
        else if (wbm_adr_o == ADR_DIG) n_dig <= n_dig + 1;
      end else if (wbm_cyc_o && wbm_stb_o && !(mute_first_wr && wbm_we_o && n_wr == 0)) begin
        ack   <= 1'b1;
        rdata <= read_val(wbm_adr_o);
      end else begin
        ack <= 1'b0;
      end
    end
  end

  // ---------------- checking and scoreboard ----------------
  int          n_total = 0, n_bad = 0;
  op_t         exp_q [$];
  logic [31:0] cur_words [16];
  bit          abort = 1'b0;

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic push(input logic we, input logic [31:0] adr, input logic [31:0] dat);
    exp_q.push_back('{we, adr, dat});
  endtask

  task automatic push_prefix(input int n_msg);
`ifdef SHA1_SEQ_IDCHECK_EN
    push(1'b0, ADR_ID, 32'h0);
`endif
    push(1'b1, ADR_OPS, 32'h2);
    for (int i = 0; i < n_msg; i++) push(1'b1, ADR_MSG, cur_words[i]);
  endtask

  task automatic push_polls(input int n);
    for (int i = 0; i < n; i++) push(1'b0, ADR_OPS, 32'h0);
  endtask

  task automatic push_dig_off();
    for (int i = 0; i < 5; i++) push(1'b0, ADR_DIG, 32'h0);
    push(1'b1, ADR_OPS, 32'h0);
  endtask

  task automatic drain();
    int n;
    n = exp_q.size();
    check("op_count", obs_n, n);
    for (int i = 0; i < n && i < obs_n; i++) begin
      op_t e;
      e = exp_q.pop_front();
      check($sformatf("op%0d", i), obs_mem[i], e);
    end
    exp_q.delete();
  endtask

  task automatic prep(input bit rst_dut, input bit mute, input bit panic, input bit never,
                      input logic [31:0] idv);
    @(negedge wb_clk_i);
    if (rst_dut) reset = 1'b1;
    clr_req = 1'b1; start = 1'b0; msg_valid = 1'b0; abort = 1'b0;
    mute_first_wr = mute; panic_mode = panic; never_done = never; id_value = idv;
    exp_q.delete();
    repeat (2) @(negedge wb_clk_i);
    reset = 1'b0; clr_req = 1'b0;
    @(negedge wb_clk_i);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge wb_clk_i);
    start = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, output bit ok);
    int t;
    t = 0;
    ok = 1'b0;
    msg_valid = 1'b1;
    msg_data = w;
    while (!msg_ready && !abort && t < 400) begin @(negedge wb_clk_i); t++; end
    if (msg_ready && !abort) begin @(negedge wb_clk_i); ok = 1'b1; end
    msg_valid = 1'b0;
  endtask

  task automatic feed(input int gap, input bit extra);
    for (int i = 0; i < 16; i++) begin
      bit ok;
      if (abort) break;
      send_word(cur_words[i], ok);
      if (!abort) check($sformatf("word%0d_accept", i), ok, 1);
      if (extra && i == 5) pulse_start();
      repeat (gap) @(negedge wb_clk_i);
    end
  endtask

  task automatic wait_end(input int budget);
    int t;
    t = 0;
    while (!(done || error) && t < budget) begin @(negedge wb_clk_i); t++; end
    check("end_reached", done || error, 1);
  endtask

  task automatic run_full(input bit rst_dut, input int gap, input bit extra);
    prep(rst_dut, 1'b0, 1'b0, 1'b0, ID_OK);
    push_prefix(16); push_polls(3); push_dig_off();
    pulse_start();
    fork
      feed(gap, extra);
      wait_end(3000);
    join
    drain();
    check("full_done", done, 1);
    check("full_busy", busy, 0);
    check("full_error", error, 0);
    check("full_digest", digest_o, {dig_words[4], dig_words[3], dig_words[2], dig_words[1], dig_words[0]});
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; msg_valid = 1'b0; msg_data = '0;
    repeat (3) @(negedge wb_clk_i);
    reset = 1'b0; clr_req = 1'b0;
    @(negedge wb_clk_i);

    check("rst_cyc", wbm_cyc_o, 0);
    check("rst_stb", wbm_stb_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_ready", msg_ready, 0);
    check("rst_digest", digest_o, 0);
    check("rst_sel", wbm_sel_o, 4'hF);

    // "abc" block, words back to back
    cur_words[0] = 32'h6162_6380;
    for (int i = 1; i < 15; i++) cur_words[i] = 32'h0;
    cur_words[15] = 32'h0000_0018;
    run_full(1'b1, 0, 1'b0);

    // first write never acknowledged
    prep(1'b1, 1'b1, 1'b0, 1'b0, ID_OK);
`ifdef SHA1_SEQ_IDCHECK_EN
    push(1'b0, ADR_ID, 32'h0);
`endif
    pulse_start();
    wait_end(500);
    drain();
    check("tmo_stb_cycles", max_run, TMO);
    check("tmo_cyc_low", wbm_cyc_o, 0);
    check("tmo_error", error, 1);
    check("tmo_code", err_code, 1);
    check("tmo_busy", busy, 0);

    // panic on the third poll (done bit also set there)
    prep(1'b1, 1'b0, 1'b1, 1'b0, ID_OK);
    push_prefix(16); push_polls(3);
    pulse_start();
    fork feed(0, 1'b0); wait_end(3000); join
    drain();
    check("panic_code", err_code, 2);
    check("panic_error", error, 1);
    check("panic_digest", digest_o, 0);

    // done never reported
    prep(1'b1, 1'b0, 1'b0, 1'b1, ID_OK);
    push_prefix(16); push_polls(MAXP);
    pulse_start();
    fork feed(0, 1'b0); wait_end(40000); join
    drain();
    check("poll_code", err_code, 3);
    check("poll_busy", busy, 0);

    // gapped words plus a start pulse while busy
    for (int i = 0; i < 16; i++) cur_words[i] = 32'h1000_0001 * (i + 1) ^ 32'hA5A5_0000;
    run_full(1'b1, 4, 1'b1);

    // reset during the 8th message write
    prep(1'b1, 1'b0, 1'b0, 1'b0, ID_OK);
    push_prefix(7);
    pulse_start();
    fork
      feed(0, 1'b0);
      begin
        int t;
        t = 0;
        while (!(wbm_cyc_o && wbm_we_o && wbm_adr_o == ADR_MSG && obs_n == PRE_OPS + 7) && t < 2000) begin
          @(negedge wb_clk_i); t++;
        end
        check("mid_write_seen", wbm_adr_o, ADR_MSG);
        reset = 1'b1;
        abort = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("mid_rst_cyc", wbm_cyc_o, 0);
        check("mid_rst_stb", wbm_stb_o, 0);
        check("mid_rst_we", wbm_we_o, 0);
        check("mid_rst_adr", wbm_adr_o, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", msg_ready, 0);
        check("mid_rst_flags", {done, error, err_code}, 0);
        @(negedge wb_clk_i);
        reset = 1'b0;
        repeat (2) @(negedge wb_clk_i);
      end
    join
    drain();
    check("post_rst_idle", wbm_cyc_o, 0);
    cur_words[0] = 32'h6162_6380;
    for (int i = 1; i < 15; i++) cur_words[i] = 32'h0;
    cur_words[15] = 32'h0000_0018;
    run_full(1'b0, 0, 1'b0);

`ifdef SHA1_SEQ_IDCHECK_EN
    // wrong peripheral ID: no writes may follow
    prep(1'b1, 1'b0, 1'b0, 1'b0, 32'hF00D_F00D);
    push(1'b0, ADR_ID, 32'h0);
    pulse_start();
    wait_end(300);
    repeat (10) @(negedge wb_clk_i);
    drain();
    check("id_code", err_code, 4);
    check("id_error", error, 1);
    check("id_writes", n_wr, 0);
`endif

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/sha1_wb_sequencer.md
Name: sha1_wb_sequencer

Overview:
- Wishbone master that sequences one SHA-1 block through the SHA-1 Wishbone peripheral with no CPU involvement.
- Accepts 16 message words on a valid/ready stream and drives the peripheral's register map: reset, 16 message writes, done polling, 5 digest reads, turn-off.
- Presents the 160-bit digest and a done/error status to the caller.
- Sits beside the peripheral on the user-project Wishbone bus, as an alternative master to the management core.

Parameters:
- BASE_ADDRESS, 32'h30000024, peripheral base. Registers: +0x8 OPS, +0xC MSG_IN, +0x10 DIGEST, +0x14 PANIC, +0x4 ID.
- POLL_GAP, 8, idle cycles between successive OPS polls (1..255).
- ACK_TIMEOUT, 32, cycles with stb high and no ack before error (2..255).
- MAX_POLLS, 1024, OPS reads without DONE before error.

Ports:
- wb_clk_i  in  1  clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a block when idle
- msg_valid  in  1  message word valid
- msg_data  in  32  message word; word 0 first
- msg_ready  out  1  word accepted when valid&ready
- busy  out  1  high from accepted start until done/error
- done  out  1  high from completion until next start or reset
- error  out  1  high from fault until next start or reset
- err_code  out  3  1=ack timeout, 2=panic, 3=poll limit, 4=ID mismatch
- digest_o  out  160  read i (i=0..4) stored in [32*i+31:32*i]
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  bus controls
- wbm_sel_o  out  4  always 4'hF
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge

Behaviour:
- Reset (any cycle, including mid-transaction): state IDLE. All outputs 0, digest_o 0, counters 0. Any in-flight bus cycle is abandoned.
- Bus cycle:
  - cyc, stb, we, adr and dat are registered and asserted together, then held until the first edge with wbm_ack_i=1.
  - On that edge, read data is captured and cyc/stb drop.
  - Next request is issued no earlier than 2 cycles later. The peripheral can raise a trailing ack, so ack is ignored while stb is low.
  - ACK_TIMEOUT cycles without ack: drop stb, go to ERROR with code 1.
- States:
  - IDLE: start=1 sets busy, clears done/error/digest and goes to RST_WR. start is ignored while busy.
  - RST_WR: write OPS=0x2 (reset, off) -> MSG_WAIT.
  - MSG_WAIT: msg_ready=1 only in this state. Holding a word moves to MSG_WR. The 4-bit word counter sits at 0..15.
  - MSG_WR: write MSG_IN with the held word. After ack, counter 15 -> POLL_WAIT; otherwise increment and return to MSG_WAIT. Exactly 16 writes; the peripheral self-starts on the 16th.
  - POLL_WAIT: count POLL_GAP cycles -> POLL_RD.
  - POLL_RD: read OPS.
    - Bit2 (panic) set -> ERROR code 2; panic takes priority if bits 2 and 3 are both set.
    - Else bit3 (done) set -> DIG_RD.
    - Else increment poll count; if count equals MAX_POLLS -> ERROR code 3; else -> POLL_WAIT.
  - DIG_RD: 5 consecutive reads of DIGEST, read index 0..4, data stored per digest_o mapping -> OFF_WR.
  - OFF_WR: write OPS=0x0 -> DONE.
  - DONE: busy=0, done=1. start re-enters RST_WR.
  - ERROR: busy=0, error=1. No bus activity. start clears error and restarts at RST_WR.
- msg_valid without a pending message slot is ignored (msg_ready=0). The caller must not drop a word once it is presented.
- Counters saturate; none wrap.

Optional Feature:
- Macro SHA1_SEQ_IDCHECK_EN.
- Defined: RST_WR is preceded by ID_RD, which reads BASE+0x4. If the value is not 32'h53484131 -> ERROR code 4, and no write is issued.
- Undefined: ID_RD is absent, code 4 is never produced, and start goes directly to RST_WR.

Test Plan:
- "abc" block (words 0x61626380, 14x 0x00000000, 0x00000018) against a behavioural register-map target model. Required bus trace: OPS<=2, 16 MSG_IN writes, ≥1 OPS read, 5 DIGEST reads, OPS<=0. digest_o equals the model's 5 returned words in read order; done=1, busy=0.
- Target never acks the first write -> stb held exactly ACK_TIMEOUT cycles then dropped; error=1, err_code=1.
- Model sets OPS bit2 on the 3rd poll -> ERROR code 2 and no DIGEST reads. Separately, DONE never set -> ERROR code 3 after exactly MAX_POLLS reads.
- msg_valid gapped (1 word every 5 cycles) plus a start pulse while busy -> still exactly 16 writes, data in order, second start ignored.
- reset asserted during the 8th MSG_IN write -> next cycle cyc=stb=0, all outputs 0. A fresh start runs a complete, correct block.
- With SHA1_SEQ_IDCHECK_EN, ID read returns 0xF00DF00D -> err_code=4, no writes issued. With ID 0x53484131 -> normal completion.
